latency_credit_sink: RTL and testbench

Consumer-side endpoint for the BSRAM-backed FIFO read port. That port returns a word a fixed number of cycles after a read request and cannot be back-pressured once the request is issued. This block issues read requests only when it holds enough credit to absorb every in-flight word. It stores returning words in a small register buffer and presents them downstream on a standard valid/ready stream. It sits between the memory FIFO's read interface and any stalling consumer, such as a packet formatter or UART TX.

---
 rtl/latency_credit_sink.sv | 143 ++++++++++++++
 tb/tb_latency_credit_sink.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_credit_sink.sv
// Credit-gated consumer for a fixed-latency, non-stallable FIFO read port; re-times words onto valid/ready.
// Optional LATENCY_CREDIT_SINK_STATS_EN enables the 16-bit received-word counter on rx_count_o.
module latency_credit_sink #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned RD_LATENCY = 6,
  parameter int unsigned BUF_DEPTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [DATA_WIDTH-1:0]       up_data_i,
  input  logic                        up_valid_i,
  input  logic                        up_empty_i,
  output logic                        up_ready_o,
  output logic [DATA_WIDTH-1:0]       m_data_o,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  input  logic                        flush_i,
  output logic                        busy_o,
  output logic [$clog2(BUF_DEPTH):0]  inflight_o,
  output logic [$clog2(BUF_DEPTH):0]  level_o,
  output logic                        overflow_o,
  output logic [15:0]                 rx_count_o
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(BUF_DEPTH);

  // Every in-flight word must have a guaranteed slot, and pointer wrap relies on a power-of-2 depth.
  if ((BUF_DEPTH < RD_LATENCY + 1) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("latency_credit_sink: BUF_DEPTH must be a power of 2 and >= RD_LATENCY + 1");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, inflight_q;
  logic [PW-1:0]         level;
  logic [PW:0]           used;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic                  overflow_q;
  logic                  full, empty, credit_ok, clearing;
  logic                  push, pop, inflight_dec;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // Occupied plus promised slots, one bit wider so the comparison never wraps.
  assign used      = {1'b0, level} + {1'b0, inflight_q};
  assign credit_ok = (used < DEPTH_W);
  assign clearing  = (state_q == ST_CLEAR);

  assign push         = up_valid_i && !full && !clearing;
  assign pop          = m_valid_o && m_ready_i;
  assign inflight_dec = up_valid_i && (inflight_q != '0);

  // Next-state and stream-side handshakes.
  always_comb begin
    state_d    = state_q;
    up_ready_o = 1'b0;
    m_valid_o  = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        up_ready_o = rst_n_i && !up_empty_i && credit_ok;
        m_valid_o  = !empty;
        if (flush_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        m_valid_o = !empty;
        busy_o    = 1'b1;
        if (inflight_q == '0) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy_o  = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clearing) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({up_ready_o, inflight_dec})
        2'b10:   inflight_q <= inflight_q + PW'(1);
        2'b01:   inflight_q <= inflight_q - PW'(1);
        default: inflight_q <= inflight_q;
      endcase
      // A return with no slot or with nothing requested means upstream broke the contract.
      if (up_valid_i && (full || (inflight_q == '0))) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= up_data_i;
    end
  end

  assign m_data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign inflight_o = inflight_q;
  assign level_o    = level;
  assign overflow_o = overflow_q;

`ifdef LATENCY_CREDIT_SINK_STATS_EN
  logic [15:0] rx_count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_count_q <= '0;
    end else if (clearing) begin
      rx_count_q <= '0;
    end else if (push) begin
      rx_count_q <= rx_count_q + 16'(1);
    end
  end

  assign rx_count_o = rx_count_q;
`else
  assign rx_count_o = '0;
`endif

endmodule

// File: tb/tb_latency_credit_sink.sv
// Directed bench for latency_credit_sink with a fixed-latency upstream FIFO model.
module tb_latency_credit_sink;

  localparam int unsigned DW     = 11;
  localparam int unsigned PW     = 4;
  localparam int          RD_LAT = 6;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [DW-1:0] up_data_i;
  logic          up_valid_i;
  logic          up_empty_i;
  logic          up_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          flush_i;
  logic          busy_o;
  logic [PW-1:0] inflight_o;
  logic [PW-1:0] level_o;
  logic          overflow_o;
  logic [15:0]   rx_count_o;

  latency_credit_sink #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(RD_LAT),
    .BUF_DEPTH (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .up_data_i  (up_data_i),
    .up_valid_i (up_valid_i),
    .up_empty_i (up_empty_i),
    .up_ready_o (up_ready_o),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .inflight_o (inflight_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .rx_count_o (rx_count_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            req_cnt, busy_cnt, first_req, first_out, last_out, max_infl, max_lvl;
  logic          last_busy_mv;
  ret_t          ret_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] out_q[$];

  task automatic clear_model();
    ret_q.delete();
    src_q.delete();
    out_q.delete();
    req_cnt = 0; busy_cnt = 0; first_req = -1; first_out = -1; last_out = -1;
    max_infl = 0; max_lvl = 0; last_busy_mv = 1'b0;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) src_q.push_back(DW'(base + i));
    if (n > 0) up_empty_i = 1'b0;
  endtask

  // One clock: observe mid-cycle, then play the upstream FIFO just after the edge.
  task automatic tick();
    ret_t r;
    @(negedge clk_i);
    if (up_ready_o) begin
      if (src_q.size() == 0) begin
        n_chk++;
        $display("FAIL req_while_empty: up_ready_o=1 with up_empty_i=%0b", up_empty_i);
        r.data = 'x;
      end else begin
        r.data = src_q.pop_front();
      end
      r.due = cyc + RD_LAT;
      ret_q.push_back(r);
      req_cnt++;
      if (first_req < 0) first_req = cyc;
    end
    if (m_valid_o && m_ready_i) begin
      out_q.push_back(m_data_o);
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (int'(inflight_o) > max_infl) max_infl = int'(inflight_o);
    if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
    if (busy_o) begin
      busy_cnt++;
      last_busy_mv = m_valid_o;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    up_valid_i = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      up_valid_i = 1'b1;
      up_data_i  = r.data;
    end
    up_empty_i = (src_q.size() == 0);
  endtask

  task automatic do_reset();
    rst_n_i    = 1'b0;
    up_valid_i = 1'b0;
    up_data_i  = '0;
    up_empty_i = 1'b1;
    m_ready_i  = 1'b0;
    flush_i    = 1'b0;
    clear_model();
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n_i    = 1'b0;
    up_empty_i = 1'b0;
    #2;
    n_chk++; if (up_ready_o !== 1'b0) $display("FAIL rst_up_ready: got %0b want 0", up_ready_o); else n_pass++;
    n_chk++; if (m_valid_o !== 1'b0) $display("FAIL rst_m_valid: got %0b want 0", m_valid_o); else n_pass++;
    n_chk++; if (m_data_o !== '0) $display("FAIL rst_m_data: got %0h want 0", m_data_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy_o); else n_pass++;
    n_chk++; if (inflight_o !== '0) $display("FAIL rst_inflight: got %0d want 0", inflight_o); else n_pass++;
    n_chk++; if (level_o !== '0) $display("FAIL rst_level: got %0d want 0", level_o); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL rst_overflow: got %0b want 0", overflow_o); else n_pass++;
    n_chk++; if (rx_count_o !== 16'd0) $display("FAIL rst_rx_count: got %0d want 0", rx_count_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_stream();
    int n;
    do_reset();
    load(20, 'h100);
    m_ready_i = 1'b1;
    n = 0;
    while (out_q.size() < 20 && n < 80) begin tick(); n++; end
    n_chk++; if (out_q.size() != 20) $display("FAIL stream_count: got %0d want 20", out_q.size()); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] got;
      got = (i < out_q.size()) ? out_q[i] : 'x;
      n_chk++; if (got !== DW'('h100 + i)) $display("FAIL stream_word%0d: got %0h want %0h", i, got, 'h100 + i); else n_pass++;
    end
    n_chk++; if (first_out - first_req != 7) $display("FAIL stream_fill: got %0d want 7", first_out - first_req); else n_pass++;
    n_chk++; if (last_out - first_out != 19) $display("FAIL stream_rate: got %0d want 19", last_out - first_out); else n_pass++;
    n_chk++; if (max_infl > 8) $display("FAIL stream_inflight_max: got %0d want <=8", max_infl); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL stream_overflow: got %0b want 0", overflow_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    load(20, 'h200);
    repeat (30) tick();
    n_chk++; if (req_cnt != 8) $display("FAIL bp_req_cycles: got %0d want 8", req_cnt); else n_pass++;
    n_chk++; if (level_o !== 4'd8) $display("FAIL bp_level: got %0d want 8", level_o); else n_pass++;
    n_chk++; if (m_valid_o !== 1'b1) $display("FAIL bp_m_valid: got %0b want 1", m_valid_o); else n_pass++;
    n_chk++; if (up_ready_o !== 1'b0) $display("FAIL bp_up_ready: got %0b want 0", up_ready_o); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL bp_overflow: got %0b want 0", overflow_o); else n_pass++;
    m_ready_i = 1'b1;
    n = 0;
    while (out_q.size() < 20 && n < 80) begin tick(); n++; end
    n_chk++; if (out_q.size() != 20) $display("FAIL bp_count: got %0d want 20", out_q.size()); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] got;
      got = (i < out_q.size()) ? out_q[i] : 'x;
      n_chk++; if (got !== DW'('h200 + i)) $display("FAIL bp_word%0d: got %0h want %0h", i, got, 'h200 + i); else n_pass++;
    end
  endtask

  task automatic test_flush();
    int n, req_before;
    do_reset();
    load(5, 'h300);
    n = 0;
    while (level_o != 4'd2 && n < 20) begin tick(); n++; end
    n_chk++; if (level_o !== 4'd2) $display("FAIL flush_setup_level: got %0d want 2", level_o); else n_pass++;
    n_chk++; if (inflight_o !== 4'd3) $display("FAIL flush_setup_inflight: got %0d want 3", inflight_o); else n_pass++;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    load(2, 'h350);
    busy_cnt = 0;
    max_lvl = 0;
    req_before = req_cnt;
    n = 0;
    while (busy_o && n < 20) begin tick(); n++; end
    n_chk++; if (req_cnt != req_before) $display("FAIL flush_no_req: got %0d want %0d", req_cnt, req_before); else n_pass++;
    n_chk++; if (busy_cnt != 4) $display("FAIL flush_busy_cycles: got %0d want 4", busy_cnt); else n_pass++;
    n_chk++; if (max_lvl != 5) $display("FAIL flush_absorbed: got %0d want 5", max_lvl); else n_pass++;
    n_chk++; if (last_busy_mv !== 1'b0) $display("FAIL flush_clear_mvalid: got %0b want 0", last_busy_mv); else n_pass++;
    n_chk++; if (level_o !== '0) $display("FAIL flush_level: got %0d want 0", level_o); else n_pass++;
    n_chk++; if (m_valid_o !== 1'b0) $display("FAIL flush_m_valid: got %0b want 0", m_valid_o); else n_pass++;
    n_chk++; if (rx_count_o !== 16'd0) $display("FAIL flush_rx_count: got %0d want 0", rx_count_o); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL flush_overflow: got %0b want 0", overflow_o); else n_pass++;
    m_ready_i = 1'b1;
    n = 0;
    while (out_q.size() < 2 && n < 30) begin tick(); n++; end
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] got;
      got = (i < out_q.size()) ? out_q[i] : 'x;
      n_chk++; if (got !== DW'('h350 + i)) $display("FAIL flush_fresh%0d: got %0h want %0h", i, got, 'h350 + i); else n_pass++;
    end
  endtask

  task automatic test_spurious();
    do_reset();
    up_valid_i = 1'b1;
    up_data_i  = DW'('h2AA);
    tick();
    n_chk++; if (overflow_o !== 1'b1) $display("FAIL spur_overflow: got %0b want 1", overflow_o); else n_pass++;
    n_chk++; if (level_o !== 4'd1) $display("FAIL spur_level: got %0d want 1", level_o); else n_pass++;
    n_chk++; if (m_data_o !== DW'('h2AA)) $display("FAIL spur_data: got %0h want 2aa", m_data_o); else n_pass++;
    n_chk++; if (inflight_o !== '0) $display("FAIL spur_inflight: got %0d want 0", inflight_o); else n_pass++;
    repeat (5) tick();
    n_chk++; if (overflow_o !== 1'b1) $display("FAIL spur_sticky: got %0b want 1", overflow_o); else n_pass++;
    rst_n_i = 1'b0;
    #1;
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL spur_reset_clear: got %0b want 0", overflow_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    load(20, 'h400);
    m_ready_i = 1'b1;
    repeat (12) tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    n_chk++; if (up_ready_o !== 1'b0) $display("FAIL arst_up_ready: got %0b want 0", up_ready_o); else n_pass++;
    n_chk++; if (m_valid_o !== 1'b0) $display("FAIL arst_m_valid: got %0b want 0", m_valid_o); else n_pass++;
    n_chk++; if (m_data_o !== '0) $display("FAIL arst_m_data: got %0h want 0", m_data_o); else n_pass++;
    n_chk++; if (inflight_o !== '0) $display("FAIL arst_inflight: got %0d want 0", inflight_o); else n_pass++;
    n_chk++; if (level_o !== '0) $display("FAIL arst_level: got %0d want 0", level_o); else n_pass++;
    clear_model();
    up_valid_i = 1'b0;
    up_empty_i = 1'b1;
    repeat (2) tick();
    rst_n_i = 1'b1;
    load(1, 'h3C5);
    n = 0;
    while (out_q.size() < 1 && n < 20) begin tick(); n++; end
    n_chk++; if (out_q.size() < 1 || out_q[0] !== DW'('h3C5)) $display("FAIL arst_fresh: got %0h want 3c5", (out_q.size() > 0) ? out_q[0] : 'x); else n_pass++;
    n_chk++; if (overflow_o !== 1'b0) $display("FAIL arst_overflow: got %0b want 0", overflow_o); else n_pass++;
  endtask

  task automatic test_stats();
    int n;
    logic [15:0] exp_cnt;
`ifdef LATENCY_CREDIT_SINK_STATS_EN
    exp_cnt = 16'd4464;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    load(70000, 0);
    m_ready_i = 1'b1;
    n = 0;
    while (out_q.size() < 70000 && n < 70100) begin tick(); n++; end
    n_chk++; if (out_q.size() != 70000) $display("FAIL stats_words: got %0d want 70000", out_q.size()); else n_pass++;
    n_chk++; if (rx_count_o !== exp_cnt) $display("FAIL stats_rx_count: got %0d want %0d", rx_count_o, exp_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_spurious();
    test_async_reset();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
